// File: rtl/puf_chall_seq.sv
// Challenge sequencer for a single-bit PUF evaluator: LFSR challenges, one evaluation per bit, packed response.
// Per bit CLR_CYC+1+k+1 cycles (k = finish delay after enable); no backpressure, a hung bit times out and sets err.
module puf_chall_seq #(
  parameter int N_BITS  = 16,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int IDX_W   = $clog2(N_BITS),
  parameter int TMO_W   = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        seed,
  input  logic              puf_resp,
  input  logic              puf_finish,
  output logic [7:0]        chall,
  output logic              puf_en,
  output logic              puf_rst,
  output logic [N_BITS-1:0] resp_word,
  output logic              resp_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    clr_d   = clr_q;
    resp_d  = resp_q;
    vld_d   = vld_q;
    err_d   = err_q;
    puf_en  = 1'b0;
    puf_rst = 1'b1;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // An all-zero seed would lock the LFSR at zero forever.
          lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
          idx_d   = '0;
          resp_d  = '0;
          vld_d   = 1'b0;
          err_d   = 1'b0;
          clr_d   = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        if (clr_q == CLR_W'(CLR_CYC - 1)) begin
          clr_d   = '0;
          state_d = S_ARM;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      S_ARM: begin
        puf_rst = 1'b0;
        puf_en  = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        puf_rst = 1'b0;
        tmo_d   = tmo_q + 1'b1;
        if (puf_finish) begin
          resp_d[idx_q] = puf_resp;
          state_d       = S_NEXT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          resp_d[idx_q] = 1'b0;
          err_d         = 1'b1;
          state_d       = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_W'(N_BITS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          lfsr_d  = lfsr_step(lfsr_q);
          clr_d   = '0;
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      lfsr_d  = lfsr_q;
      idx_d   = idx_q;
      resp_d  = resp_q;
      err_d   = err_q;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      idx_q   <= '0;
      tmo_q   <= '0;
      clr_q   <= '0;
      resp_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      clr_q   <= clr_d;
      resp_q  <= resp_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign chall      = lfsr_q;
  assign resp_word  = resp_q;
  assign resp_valid = vld_q;
  assign err        = err_q;

endmodule

// File: tb/tb_puf_chall_seq.sv
// Directed bench for puf_chall_seq with a small evaluator model (finish one cycle after enable).
module tb_puf_chall_seq;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   seed = 8'h00;
  logic         puf_resp = 1'b0;
  logic         puf_finish = 1'b0;
  logic [7:0]   chall;
  logic         puf_en, puf_rst, resp_valid, busy, done, err;
  logic [N-1:0] resp_word;

  puf_chall_seq #(.N_BITS(N), .CLR_CYC(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .puf_resp(puf_resp), .puf_finish(puf_finish), .chall(chall),
    .puf_en(puf_en), .puf_rst(puf_rst), .resp_word(resp_word),
    .resp_valid(resp_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Evaluator model: answers in the cycle after the enable pulse unless told to hang that bit.
  int         en_cnt = 0;
  int         hang_bit = -1;
  int         resp_sel = 0;
  bit         arm_seen = 1'b0;
  logic [7:0] ch_log [0:7];

  always @(posedge clk) begin
    #2;
    puf_finish = 1'b0;
    if (arm_seen) begin
      arm_seen = 1'b0;
      if (en_cnt - 1 != hang_bit) begin
        puf_finish = 1'b1;
        puf_resp   = chall[resp_sel];
      end
    end
    if (puf_en) begin
      if (en_cnt < 8) ch_log[en_cnt] = chall;
      en_cnt++;
      arm_seen = 1'b1;
    end
  end

  task automatic run(input logic [7:0] s, input int poke, output int lat, output int dn);
    en_cnt   = 0;
    arm_seen = 1'b0;
    dn       = 0;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 400) begin
      if (lat == poke) begin
        start = 1'b1;
        seed  = 8'hA5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("run_done_seen", done, 1'b1);
    if (done) dn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
  endtask

  task automatic wait_en(input int n);
    int g;
    g = 0;
    while (en_cnt < n && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wait_en_reached", (en_cnt >= n), 1'b1);
  endtask

  initial begin
    int lat, dn, seen;

    #12;
    chk("rst_chall", chall, 8'h01);
    chk("rst_resp", resp_word, 4'h0);
    chk("rst_vld", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_en", puf_en, 1'b0);
    chk("rst_prst", puf_rst, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run, seed 0x01, response = chall[0]
    resp_sel = 0; hang_bit = -1;
    run(8'h01, 0, lat, dn);
    chk("r1_lat", lat, 21);
    chk("r1_resp", resp_word, 4'b0001);
    chk("r1_err", err, 1'b0);
    chk("r1_vld", resp_valid, 1'b1);
    chk("r1_dn", dn, 1);
    chk("r1_busy", busy, 1'b0);
    chk("r1_ch0", ch_log[0], 8'h01);
    chk("r1_ch1", ch_log[1], 8'hB8);
    chk("r1_ch2", ch_log[2], 8'h5C);
    chk("r1_ch3", ch_log[3], 8'h2E);

    // Zero seed behaves as 0x01
    run(8'h00, 0, lat, dn);
    chk("r0_lat", lat, 21);
    chk("r0_ch0", ch_log[0], 8'h01);
    chk("r0_ch3", ch_log[3], 8'h2E);
    chk("r0_resp", resp_word, 4'b0001);

    // Other seed: A5, EA, 75, 82
    run(8'hA5, 0, lat, dn);
    chk("ra_ch1", ch_log[1], 8'hEA);
    chk("ra_ch2", ch_log[2], 8'h75);
    chk("ra_ch3", ch_log[3], 8'h82);
    chk("ra_resp", resp_word, 4'b0101);

    // Timeout on bit 1, response = chall[3] -> 0,1,1,1 with bit 1 forced 0
    resp_sel = 3; hang_bit = 1;
    run(8'h01, 0, lat, dn);
    chk("to_lat", lat, 28);
    chk("to_resp", resp_word, 4'b1100);
    chk("to_err", err, 1'b1);
    chk("to_vld", resp_valid, 1'b1);
    chk("to_dn", dn, 1);

    // Abort in WAIT of bit 2 (bit 1 has already timed out)
    resp_sel = 0; hang_bit = 1;
    en_cnt = 0; arm_seen = 1'b0;
    @(negedge clk);
    seed = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(3);
    @(negedge clk);
    chk("ab_in_wait", {busy, puf_rst, puf_en}, 3'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_prst", puf_rst, 1'b1);
    chk("ab_en", puf_en, 1'b0);
    chk("ab_vld", resp_valid, 1'b0);
    chk("ab_err", err, 1'b1);
    chk("ab_resp", resp_word, 4'b0001);
    chk("ab_done", done, 1'b0);
    hang_bit = -1;
    run(8'h01, 0, lat, dn);
    chk("ab_rerun_lat", lat, 21);
    chk("ab_rerun_err", err, 1'b0);
    chk("ab_rerun_resp", resp_word, 4'b0001);

    // Start pulsed mid-run is ignored
    resp_sel = 3;
    run(8'h01, 7, lat, dn);
    chk("bs_lat", lat, 21);
    chk("bs_resp", resp_word, 4'b1110);
    chk("bs_ch1", ch_log[1], 8'hB8);
    chk("bs_dn", dn, 1);

    // start + abort together in IDLE
    @(negedge clk);
    seed = 8'hA5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    chk("sa_idle", seen, 0);
    chk("sa_vld", resp_valid, 1'b0);
    chk("sa_resp", resp_word, 4'b1110);
    chk("sa_chall", chall, 8'h2E);

    // Asynchronous reset mid-WAIT of bit 2
    resp_sel = 0; hang_bit = 1;
    en_cnt = 0; arm_seen = 1'b0;
    @(negedge clk);
    seed = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en(3);
    @(negedge clk);
    chk("ar_pre_err", err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_chall", chall, 8'h01);
    chk("ar_resp", resp_word, 4'h0);
    chk("ar_err", err, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_prst_en", {puf_rst, puf_en}, 2'b10);
    chk("ar_vld_done", {resp_valid, done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
